// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the instruction memory. A byte stream arrives over a
// valid/ready handshake. The loader assembles big-endian 32-bit words and
// writes them to consecutive word-aligned byte addresses starting at
// BASE_ADDR. The CPU is held in reset until a load completes successfully.
//
// Stream layout:
//   count byte N (1..MAX_WORDS), then N*4 payload bytes, MSB first, then
//   (only with IMEM_LOADER_CHECKSUM_EN) one byte equal to the XOR of all
//   payload bytes.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   defined   : CHECK state and XOR accumulator present; trailing byte checked.
//   undefined : the last WRITE goes straight to DONE.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both 1. byte_ready is registered and depends only on the
// state, never on byte_valid. byte_data is ignored on any other edge.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   one-cycle pulse; begins a load from IDLE, DONE or ERROR
//   byte_valid in   byte_data holds a stream byte
//   byte_data  in   [7:0] stream byte
//   byte_ready out  loader accepts a byte this cycle (COUNT, DATA, CHECK)
//   mem_we     out  instruction-memory write strobe, one cycle per word
//   mem_addr   out  [ADDR_W-1:0] byte address of the word being written
//   mem_wdata  out  [31:0] word being written
//   cpu_hold   out  CPU reset request; low only after a successful load
//   done       out  load completed successfully (level)
//   error      out  load aborted (level)
//   state      out  [2:0] FSM state for observation:
//                   0 IDLE, 1 COUNT, 2 DATA, 3 WRITE, 4 CHECK, 5 DONE, 6 ERROR
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    state_t      state_q;
    logic [1:0]  byte_cnt;     // payload bytes already taken for the current word
    logic [23:0] shift_q;      // first three bytes of the current word
    logic [7:0]  word_count;   // N from the count byte
    logic [7:0]  word_idx;     // k, index of the word being assembled
    logic [8:0]  idx_next;     // k+1, one bit wider so N=255 cannot wrap
    logic        xfer;
    logic [31:0] word_full;
    logic        count_bad;
    logic [ADDR_W-1:0] word_addr;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_acc;      // running XOR of payload bytes
`endif

    assign xfer      = byte_valid & byte_ready;
    // Word as it stands once the current byte is shifted in; only meaningful
    // on the edge that takes the 4th byte.
    assign word_full = {shift_q, byte_data};
    assign idx_next  = {1'b0, word_idx} + 9'd1;
    assign count_bad = (byte_data == 8'd0) || (32'(byte_data) > 32'(MAX_WORDS));
    // Address arithmetic wraps modulo 2^ADDR_W by truncation.
    assign word_addr = BASE_A + ADDR_W'({word_idx, 2'b00});
    assign state     = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_A;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_cnt   <= 2'd0;
            shift_q    <= 24'd0;
            word_count <= 8'd0;
            word_idx   <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc    <= 8'd0;
`endif
        end else begin
            // The strobe is only ever raised for the single WRITE cycle.
            mem_we <= 1'b0;

            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_q    <= ST_COUNT;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        byte_cnt   <= 2'd0;
                        word_idx   <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_acc    <= 8'd0;
`endif
                    end
                end

                ST_COUNT: begin
                    if (xfer) begin
                        if (count_bad) begin
                            state_q    <= ST_ERROR;
                            byte_ready <= 1'b0;
                            error      <= 1'b1;
                            cpu_hold   <= 1'b1;
                        end else begin
                            state_q    <= ST_DATA;
                            word_count <= byte_data;
                            word_idx   <= 8'd0;
                            byte_cnt   <= 2'd0;
                        end
                    end
                end

                ST_DATA: begin
                    if (xfer) begin
                        shift_q <= word_full[23:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_acc <= xor_acc ^ byte_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            // 4th byte: present the word for exactly one cycle.
                            state_q    <= ST_WRITE;
                            byte_ready <= 1'b0;
                            byte_cnt   <= 2'd0;
                            mem_we     <= 1'b1;
                            mem_addr   <= word_addr;
                            mem_wdata  <= word_full;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                ST_WRITE: begin
                    word_idx <= idx_next[7:0];
                    if (idx_next < {1'b0, word_count}) begin
                        state_q    <= ST_DATA;
                        byte_ready <= 1'b1;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q    <= ST_CHECK;
                        byte_ready <= 1'b1;
`else
                        state_q    <= ST_DONE;
                        byte_ready <= 1'b0;
                        done       <= 1'b1;
                        cpu_hold   <= 1'b0;
`endif
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        if (byte_data == xor_acc) begin
                            state_q  <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state_q  <= ST_ERROR;
                            error    <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    // Unreachable encodings fall back to a safe idle.
                    state_q    <= ST_IDLE;
                    byte_ready <= 1'b0;
                    cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int BASE   = 0;
    localparam int MAXW   = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              clk;
    logic              reset;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [2:0]        state;

    imem_loader #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [39:0] exp_q[$];      // {addr, data} of each expected write
    logic [31:0] words[$];      // image for the next load
    int start_cyc = 0;
    int rd_ptr = 0;

    // Write monitor: captures every cycle that mem_we is high.
    logic [7:0]  obs_addr [0:255];
    logic [31:0] obs_data [0:255];
    logic        obs_rdy  [0:255];
    int obs_cnt = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            obs_addr[obs_cnt[7:0]] <= mem_addr;
            obs_data[obs_cnt[7:0]] <= mem_wdata;
            obs_rdy[obs_cnt[7:0]]  <= byte_ready;
            obs_cnt <= obs_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        logic [39:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_ptr < obs_cnt) begin
                check({tag, "_addr"}, 64'(obs_addr[rd_ptr[7:0]]), 64'(e[39:32]));
                check({tag, "_data"}, 64'(obs_data[rd_ptr[7:0]]), 64'(e[31:0]));
                check({tag, "_rdy_in_write"}, 64'(obs_rdy[rd_ptr[7:0]]), 64'(0));
                rd_ptr++;
            end else begin
                check({tag, "_missing_write"}, 64'(obs_cnt), 64'(rd_ptr + 1));
                rd_ptr = obs_cnt;
            end
        end
        check({tag, "_write_count"}, 64'(obs_cnt), 64'(rd_ptr));
        rd_ptr = obs_cnt;
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and finish 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int  waited;
        bit  took;
        if (gap) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        took   = 1'b0;
        waited = 0;
        while (!took && waited < 50) begin
            @(negedge clk);
            took = byte_ready;
            @(posedge clk); #1;
            waited++;
        end
        check("byte_accept", 64'(took), 64'(1));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        check("start_clears", 64'({done, error, cpu_hold, byte_ready, state}),
              64'({1'b0, 1'b0, 1'b1, 1'b1, 3'd1}));
    endtask

    task automatic run_load(input bit gap, input bit bad_sum, input int cut);
        logic [7:0] acc;
        logic [7:0] b;
        logic [7:0] a;
        int n;
        acc = 8'h00;
        n   = 0;
        do_start();
        send_byte(8'(words.size()), gap);
        foreach (words[i]) begin
            a = 8'(BASE + 4 * i);
            if (cut < 0 || (i + 1) * 4 <= cut) exp_q.push_back({a, words[i]});
            for (int j = 3; j >= 0; j--) begin
                if (cut >= 0 && n == cut) return;
                b = words[i][8 * j +: 8];
                acc = acc ^ b;
                send_byte(b, gap);
                n++;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (bad_sum) send_byte((acc == 8'h00) ? 8'hFF : 8'h00, gap);
        else         send_byte(acc, gap);
`endif
        byte_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int g;
        bit ok;
        g = 0;
        while (!(done || error) && g < 400) begin
            @(posedge clk); #1;
            g++;
        end
        ok = done || error;
        check({tag, "_finished"}, 64'(ok), 64'(1));
    endtask

    task automatic check_result(input string tag, input bit ok);
        check({tag, "_done"},     64'(done),       64'(ok));
        check({tag, "_error"},    64'(error),      64'(!ok));
        check({tag, "_cpu_hold"}, 64'(cpu_hold),   64'(!ok));
        check({tag, "_ready"},    64'(byte_ready), 64'(0));
        check({tag, "_state"},    64'(state),      64'(ok ? 3'd5 : 3'd6));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 64'({byte_ready, mem_we, cpu_hold, done, error, state}),
              64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}));
        check("rst_addr",  64'(mem_addr),  64'(BASE));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        reset = 1'b1;

        // Idle with no start: nothing moves.
        repeat (6) @(posedge clk);
        #1;
        check("idle_outputs", 64'({byte_ready, cpu_hold, done, error, state}),
              64'({1'b0, 1'b1, 1'b0, 1'b0, 3'd0}));
        check_writes("idle");

        // Two-word load, valid held high.
        words = '{32'h20080005, 32'h01095020};
        run_load(1'b0, 1'b0, -1);
        wait_end("two");
        check("two_latency", 64'(cyc - start_cyc), 64'(1 + 5 * 2 + CS));
        check_result("two", 1'b1);
        check_writes("two");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: words still land, load fails.
        run_load(1'b0, 1'b1, -1);
        wait_end("badsum");
        check_result("badsum", 1'b0);
        check_writes("badsum");
`endif

        // Bad counts: 0 and MAX_WORDS+1, each from a fresh start.
        do_start();
        send_byte(8'h00, 1'b0);
        byte_valid = 1'b0;
        wait_end("cnt0");
        check_result("cnt0", 1'b0);
        check_writes("cnt0");
        do_start();
        send_byte(8'(MAXW + 1), 1'b0);
        byte_valid = 1'b0;
        wait_end("cnt65");
        check_result("cnt65", 1'b0);
        check_writes("cnt65");

        // Same two words with byte_valid toggling.
        words = '{32'h20080005, 32'h01095020};
        run_load(1'b1, 1'b0, -1);
        wait_end("gap");
        check_result("gap", 1'b1);
        check_writes("gap");

        // Largest legal image with random contents.
        words.delete();
        for (int i = 0; i < MAXW; i++)
            words.push_back({16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))});
        run_load(1'b0, 1'b0, -1);
        wait_end("max");
        check("max_latency", 64'(cyc - start_cyc), 64'(1 + 5 * MAXW + CS));
        check_result("max", 1'b1);
        check_writes("max");

        // Reset after the 6th payload byte.
        words = '{32'hA1B2C3D4, 32'h0F1E2D3C};
        run_load(1'b0, 1'b0, 6);
        byte_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_outputs", 64'({byte_ready, mem_we, cpu_hold, done, error, state}),
              64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}));
        check("midrst_addr",  64'(mem_addr),  64'(BASE));
        check("midrst_wdata", 64'(mem_wdata), 64'(0));
        check_writes("midrst_partial");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_hold", 64'({cpu_hold, state}), 64'({1'b1, 3'd0}));

        words = '{32'h20080005, 32'h01095020};
        run_load(1'b0, 1'b0, -1);
        wait_end("reload");
        check_result("reload", 1'b1);
        check_writes("reload");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
